// File: rtl/sample_pkg.sv
// rtl/sample_pkg.sv - shared types, defaults and result post-processing for sample_dot_acc
package sample_pkg;

  localparam int SAMPLE_DATA_W  = 13;
  localparam int SAMPLE_ACC_W   = 24;
  localparam int SAMPLE_FRAC    = 4;
  localparam int SAMPLE_MAX_LEN = 64;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_FIN = 2'd1,
    ST_OUT = 2'd2
  } state_e;

  // Round half up, drop frac bits, optional ReLU, then clamp to a data_w-bit signed range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int frac,
                                                   input int data_w,
                                                   input bit relu);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (frac > 0) begin
      r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    end
    if (relu && (r < 64'sd0)) begin
      r = 64'sd0;
    end
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_dot_acc_post.sv
// rtl/sample_dot_acc_post.sv - combinational round / ReLU / saturate of the finished accumulator
module sample_dot_acc_post
  import sample_pkg::*;
#(
  parameter int DATA_W = SAMPLE_DATA_W,
  parameter int ACC_W  = SAMPLE_ACC_W,
  parameter int FRAC   = SAMPLE_FRAC,
  parameter int RELU   = 0
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] res_o
);

  logic signed [63:0] acc_wide;

  assign acc_wide = {{(64 - ACC_W){acc_i[ACC_W-1]}}, acc_i};
  assign res_o    = DATA_W'(sat_round(acc_wide, FRAC, DATA_W, (RELU != 0)));

endmodule

// File: rtl/sample_dot_acc.sv
// rtl/sample_dot_acc.sv - bias-seeded dot-product accumulator with rounded, saturated valid/ready result
module sample_dot_acc
  import sample_pkg::*;
#(
  parameter int DATA_W  = SAMPLE_DATA_W,
  parameter int ACC_W   = SAMPLE_ACC_W,
  parameter int FRAC    = SAMPLE_FRAC,
  parameter int MAX_LEN = SAMPLE_MAX_LEN,
  parameter int RELU    = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     err_overrun
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

  state_e                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]   out_data_q, out_data_d;
  logic                       err_q, err_d;

  logic                       beat_acc;
  logic                       beat_end;
  logic signed [ACC_W-1:0]    data_ext;
  logic signed [ACC_W-1:0]    bias_seed;
  logic signed [DATA_W-1:0]   post_res;

  assign beat_acc  = in_valid && in_ready;
  assign beat_end  = in_last || (cnt_q == LAST_CNT);
  assign data_ext  = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
  assign bias_seed = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC;

  sample_dot_acc_post #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .FRAC   (FRAC),
    .RELU   (RELU)
  ) u_post (
    .acc_i (acc_q),
    .res_o (post_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACC:  if (beat_acc && beat_end) state_d = ST_FIN;
      ST_FIN:  state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_ACC);
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    unique case (state_q)
      ST_ACC: begin
        if (beat_acc) begin
          acc_d = (cnt_q == '0) ? (bias_seed + data_ext) : (acc_q + data_ext);
          cnt_d = cnt_q + CNT_W'(1);
          // Forced finish at the length limit without in_last flags the overrun.
          if ((cnt_q == LAST_CNT) && !in_last) begin
            err_d = 1'b1;
          end
        end
      end
      ST_FIN: begin
        out_data_d  = post_res;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
        end
      end
      default: ;
    endcase
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_sample_dot_acc.sv
// tb/tb_sample_dot_acc.sv - randomized self-checking bench for sample_dot_acc (RELU=0 and RELU=1 instances)
module tb_sample_dot_acc;

  logic clk;
  logic reset_n;
  logic in_valid;
  logic in_last;
  logic signed [12:0] in_data;
  logic signed [12:0] bias;
  logic out_ready;
  logic in_ready0, out_valid0, err0;
  logic in_ready1, out_valid1, err1;
  logic signed [12:0] out_data0, out_data1;

  int n_tests;
  int n_fail;

  sample_dot_acc #(.RELU(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .bias(bias), .in_ready(in_ready0), .out_valid(out_valid0),
    .out_data(out_data0), .out_ready(out_ready), .err_overrun(err0)
  );

  sample_dot_acc #(.RELU(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .bias(bias), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_data(out_data1), .out_ready(out_ready), .err_overrun(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: bias*2^4 plus the beats, rounded half up, floor-shifted, ReLU, clamped.
  function automatic longint model(input longint b, input int q[$], input bit relu);
    longint s;
    longint r;
    s = b * 16;
    foreach (q[i]) s += q[i];
    s = s + 8;
    if (s >= 0) r = s / 16;
    else r = -((-s + 15) / 16);
    if (relu && r < 0) r = 0;
    if (r > 4095) r = 4095;
    if (r < -4096) r = -4096;
    return r;
  endfunction

  task automatic beat(input int d, input bit last);
    int k;
    in_valid = 1'b1;
    in_data  = 13'(d);
    in_last  = last;
    k = 0;
    while (!in_ready0 && k < 200) begin
      step();
      k++;
    end
    if (!in_ready0) check("beat_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input int b, input int q[$], input bit with_last, input bit gaps);
    bias = 13'(b);
    foreach (q[i]) begin
      if (gaps && ($urandom_range(0, 3) == 0)) step();
      beat(q[i], with_last && (i == q.size() - 1));
    end
  endtask

  task automatic take_result(input string tag, input longint e0, input longint e1, input int hold);
    int k;
    k = 0;
    while (!out_valid0 && k < 200) begin
      step();
      k++;
    end
    check({tag, "_valid"}, out_valid0, 1);
    check({tag, "_d0"}, out_data0, e0);
    check({tag, "_d1"}, out_data1, e1);
    for (int i = 0; i < hold; i++) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid0, 0);
  endtask

  initial begin
    int q[$];
    longint e0, e1, held;
    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    bias      = '0;
    out_ready = 1'b0;

    #23;
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_err", err0, 0);
    reset_n = 1'b1;
    step();
    check("rst_in_ready", in_ready0, 1);

    // basic with latency
    q = '{16, 32, 48};
    send_vec(2, q, 1'b1, 1'b0);
    check("t1_fin_not_valid", out_valid0, 0);
    check("t1_fin_in_ready", in_ready0, 0);
    step();
    check("t1_valid_after_2", out_valid0, 1);
    take_result("t1", model(2, q, 0), model(2, q, 1), 0);
    check("t1_const", out_data0, 8);

    // rounding of negatives, ReLU instance clamps
    q = '{-8, -1};
    send_vec(0, q, 1'b1, 1'b0);
    take_result("t2", model(0, q, 0), model(0, q, 1), 0);
    check("t2_relu0", out_data0, -1);
    check("t2_relu1", out_data1, 0);

    // saturation both ways
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(4095);
    send_vec(0, q, 1'b1, 1'b0);
    take_result("t3_pos", 4095, 4095, 0);
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(-4096);
    send_vec(0, q, 1'b1, 1'b0);
    take_result("t3_neg", -4096, 0, 0);

    // backpressure: result held, pending beat waits for the handshake
    q = '{100, -7, 300};
    send_vec(-5, q, 1'b1, 1'b0);
    step();
    held = model(-5, q, 0);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 13'sd5;
    bias     = 13'sd3;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", out_valid0, 1);
      check("t4_hold_data", out_data0, held);
      check("t4_in_ready_low", in_ready0, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_released", in_ready0, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    q = '{5};
    take_result("t4_next", model(3, q, 0), model(3, q, 1), 0);

    // overrun: 64 beats, no in_last
    check("t5_err_before", err0, 0);
    q = {};
    for (int i = 0; i < 64; i++) q.push_back(1);
    send_vec(0, q, 1'b0, 1'b0);
    check("t5_forced_fin", in_ready0, 0);
    take_result("t5", 4, 4, 0);
    check("t5_err", err0, 1);

    // randomized vectors with gaps and output stalls
    for (int v = 0; v < 40; v++) begin
      int b;
      int len;
      q = {};
      len = (v % 10 == 9) ? $urandom_range(30, 63) : $urandom_range(1, 12);
      b = int'($urandom_range(0, 8191)) - 4096;
      for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 8191)) - 4096);
      e0 = model(b, q, 0);
      e1 = model(b, q, 1);
      send_vec(b, q, 1'b1, 1'b1);
      take_result($sformatf("rnd%0d", v), e0, e1, $urandom_range(0, 3));
    end
    check("t5_err_sticky", err0, 1);

    // asynchronous reset mid-vector
    bias = 13'sd7;
    beat(11, 1'b0);
    beat(22, 1'b0);
    beat(33, 1'b0);
    #2;
    reset_n = 1'b0;
    #2;
    check("t6_rst_err", err0, 0);
    check("t6_rst_valid", out_valid0, 0);
    check("t6_rst_data", out_data0, 0);
    #10;
    reset_n = 1'b1;
    step();
    check("t6_in_ready", in_ready0, 1);
    q = '{0};
    send_vec(1, q, 1'b1, 1'b0);
    take_result("t6", 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
